// File: rtl/trena_pkg.sv
// Shared definitions for the trena serial receiver: ASCII constants,
// receiver/parser state encodings and the default bit period.
// Optional feature macro used elsewhere: TRENA_RX_TIMEOUT_EN.
package trena_pkg;

   localparam logic [6:0] ASCII_ZERO = 7'h30;
   localparam logic [6:0] ASCII_NOVE = 7'h39;
   localparam logic [6:0] ASCII_HASH = 7'h23;

   // 50 MHz / 115200 baud
   localparam int CLK_POR_BIT_PADRAO = 434;

   // Receiver FSM codes, also exported on db_estado
   typedef enum logic [3:0] {
      RX_INICIAL         = 4'd0,
      RX_VERIFICA_INICIO = 4'd1,
      RX_RECEBE          = 4'd2,
      RX_STOP            = 4'd3,
      RX_ENTREGA         = 4'd4,
      RX_ESPERA_LINHA    = 4'd5
   } rx_estado_t;

   // Message parser FSM codes
   typedef enum logic [1:0] {
      P_ESPERA_C    = 2'd0,
      P_ESPERA_D    = 2'd1,
      P_ESPERA_U    = 2'd2,
      P_ESPERA_HASH = 2'd3
   } parser_estado_t;

   function automatic logic eh_digito(input logic [6:0] c);
      return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
   endfunction

endpackage

// File: rtl/trena_receptor_if.sv
// Character channel from the 7O1 deserializer to the message parser.
// Handshake: valido is a single-cycle strobe; caractere, paridade_ok and
// stop_ok are only meaningful while valido=1. There is no back-pressure:
// the consumer must accept the character in that same cycle. estado always
// carries the current receiver-FSM state.
interface trena_receptor_if;
   import trena_pkg::*;

   logic [6:0] caractere;
   logic       paridade_ok;
   logic       stop_ok;
   logic       valido;
   rx_estado_t estado;

   modport master (output caractere, paridade_ok, stop_ok, valido, estado);
   modport slave  (input  caractere, paridade_ok, stop_ok, valido, estado);
endinterface

// File: rtl/trena_receptor_rx.sv
// rx_serial_7O1: 2-FF synchronizer, bit timer and receiver FSM for
// 7 data bits LSB-first, odd parity, 1 stop bit.
module rx_serial_7O1
   import trena_pkg::*;
#(
   parameter int CLK_POR_BIT = CLK_POR_BIT_PADRAO
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              entrada_serial,
   trena_receptor_if.master  rx
);

   localparam int TW = $clog2(CLK_POR_BIT + 1);
   localparam logic [TW-1:0] FIM_BIT  = TW'(CLK_POR_BIT - 1);
   localparam logic [TW-1:0] MEIO_BIT = TW'(CLK_POR_BIT / 2 - 1);

   rx_estado_t    estado_q, estado_d;
   logic [1:0]    sync_q, sync_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    dados_q, dados_d;   // {paridade, d6..d0}
   logic          stop_q, stop_d;
   logic          linha;

   assign linha  = sync_q[1];
   assign sync_d = {sync_q[0], entrada_serial};

   // State and datapath registers; synchronizer resets to idle-high
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= RX_INICIAL;
         sync_q    <= 2'b11;
         tick_q    <= '0;
         bit_cnt_q <= '0;
         dados_q   <= '0;
         stop_q    <= 1'b1;
      end else begin
         estado_q  <= estado_d;
         sync_q    <= sync_d;
         tick_q    <= tick_d;
         bit_cnt_q <= bit_cnt_d;
         dados_q   <= dados_d;
         stop_q    <= stop_d;
      end
   end

   // Next state: mid-bit sampling driven by the bit timer
   always_comb begin
      estado_d  = estado_q;
      tick_d    = tick_q;
      bit_cnt_d = bit_cnt_q;
      dados_d   = dados_q;
      stop_d    = stop_q;
      case (estado_q)
         RX_INICIAL: begin
            if (!linha) begin
               estado_d  = RX_VERIFICA_INICIO;
               tick_d    = '0;
               bit_cnt_d = '0;
            end
         end
         RX_VERIFICA_INICIO: begin
            if (tick_q == MEIO_BIT) begin
               tick_d   = '0;
               // high at mid-start is a glitch: drop it silently
               estado_d = linha ? RX_INICIAL : RX_RECEBE;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         RX_RECEBE: begin
            if (tick_q == FIM_BIT) begin
               tick_d  = '0;
               dados_d = {linha, dados_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  estado_d = RX_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (tick_q == FIM_BIT) begin
               tick_d   = '0;
               stop_d   = linha;
               estado_d = RX_ENTREGA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         RX_ENTREGA: begin
            // rearm right away so back-to-back frames are caught
            estado_d = stop_q ? RX_INICIAL : RX_ESPERA_LINHA;
         end
         RX_ESPERA_LINHA: begin
            if (linha) estado_d = RX_INICIAL;
         end
         default: estado_d = RX_INICIAL;
      endcase
   end

   // Outputs: character strobe and status toward the parser
   always_comb begin
      rx.valido      = (estado_q == RX_ENTREGA);
      rx.caractere   = dados_q[6:0];
      rx.paridade_ok = ^dados_q;
      rx.stop_ok     = stop_q;
      rx.estado      = estado_q;
   end

endmodule

// File: rtl/trena_receptor.sv
// trena_receptor: receives 7O1 characters and parses "CDU#" messages into
// a 12-bit BCD distance with a one-cycle pronto pulse.
// Optional macro TRENA_RX_TIMEOUT_EN adds an inter-character timeout.
module trena_receptor
   import trena_pkg::*;
#(
   parameter int CLK_POR_BIT  = CLK_POR_BIT_PADRAO,
   parameter int TIMEOUT_CLKS = 50000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        erro_paridade,
   output logic        erro_formato,
   output logic [3:0]  db_estado
);

   trena_receptor_if rx_if ();

   rx_serial_7O1 #(.CLK_POR_BIT(CLK_POR_BIT)) u_rx (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .rx             (rx_if.master)
   );

   parser_estado_t parser_q, parser_d;
   logic [3:0]     cen_q, cen_d, dez_q, dez_d, uni_q, uni_d;
   logic [11:0]    medida_q, medida_d;
   logic           pronto_q, pronto_d;
   logic           erro_paridade_q, erro_paridade_d;
   logic           erro_formato_q, erro_formato_d;

`ifdef TRENA_RX_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        timeout;

   // Timeout counter: runs only while a message is partial and the line is idle
   always_comb begin
      to_cnt_d = '0;
      timeout  = 1'b0;
      if (parser_q != P_ESPERA_C && rx_if.estado == RX_INICIAL) begin
         if (to_cnt_q == 32'(TIMEOUT_CLKS - 1)) begin
            timeout = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 32'd1;
         end
      end
   end

   // Timeout counter register
   always_ff @(posedge clock) begin
      if (reset) to_cnt_q <= '0;
      else       to_cnt_q <= to_cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CLKS == 0);
`endif

   // Parser state, digit registers and registered output flags
   always_ff @(posedge clock) begin
      if (reset) begin
         parser_q        <= P_ESPERA_C;
         cen_q           <= '0;
         dez_q           <= '0;
         uni_q           <= '0;
         medida_q        <= '0;
         pronto_q        <= 1'b0;
         erro_paridade_q <= 1'b0;
         erro_formato_q  <= 1'b0;
      end else begin
         parser_q        <= parser_d;
         cen_q           <= cen_d;
         dez_q           <= dez_d;
         uni_q           <= uni_d;
         medida_q        <= medida_d;
         pronto_q        <= pronto_d;
         erro_paridade_q <= erro_paridade_d;
         erro_formato_q  <= erro_formato_d;
      end
   end

   // Next state: stop error beats parity error beats sequence error
   always_comb begin
      parser_d        = parser_q;
      cen_d           = cen_q;
      dez_d           = dez_q;
      uni_d           = uni_q;
      medida_d        = medida_q;
      pronto_d        = 1'b0;
      erro_paridade_d = 1'b0;
      erro_formato_d  = 1'b0;
      if (rx_if.valido) begin
         if (!rx_if.stop_ok) begin
            erro_formato_d = 1'b1;
            parser_d       = P_ESPERA_C;
         end else if (!rx_if.paridade_ok) begin
            erro_paridade_d = 1'b1;
            parser_d        = P_ESPERA_C;
         end else begin
            case (parser_q)
               P_ESPERA_C: begin
                  if (eh_digito(rx_if.caractere)) begin
                     cen_d    = rx_if.caractere[3:0];
                     parser_d = P_ESPERA_D;
                  end else begin
                     erro_formato_d = 1'b1;
                     parser_d       = P_ESPERA_C;
                  end
               end
               P_ESPERA_D: begin
                  if (eh_digito(rx_if.caractere)) begin
                     dez_d    = rx_if.caractere[3:0];
                     parser_d = P_ESPERA_U;
                  end else begin
                     erro_formato_d = 1'b1;
                     parser_d       = P_ESPERA_C;
                  end
               end
               P_ESPERA_U: begin
                  if (eh_digito(rx_if.caractere)) begin
                     uni_d    = rx_if.caractere[3:0];
                     parser_d = P_ESPERA_HASH;
                  end else begin
                     erro_formato_d = 1'b1;
                     parser_d       = P_ESPERA_C;
                  end
               end
               P_ESPERA_HASH: begin
                  if (rx_if.caractere == ASCII_HASH) begin
                     pronto_d = 1'b1;
                     medida_d = {cen_q, dez_q, uni_q};
                  end else begin
                     erro_formato_d = 1'b1;
                  end
                  parser_d = P_ESPERA_C;
               end
               default: parser_d = P_ESPERA_C;
            endcase
         end
      end
`ifdef TRENA_RX_TIMEOUT_EN
      if (timeout) begin
         erro_formato_d = 1'b1;
         parser_d       = P_ESPERA_C;
      end
`endif
   end

   // Outputs straight from registers
   always_comb begin
      medida        = medida_q;
      pronto        = pronto_q;
      erro_paridade = erro_paridade_q;
      erro_formato  = erro_formato_q;
      db_estado     = rx_if.estado;
   end

endmodule

// File: tb/tb_trena_receptor.sv
// Directed bench for trena_receptor: drives 7O1 frames on entrada_serial
// and checks medida, pronto, error pulses and the receiver state code.
module tb_trena_receptor;

   localparam int CPB     = 32;
   localparam int TO_CLKS = 5000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        entrada_serial = 1'b1;
   logic [11:0] medida;
   logic        pronto, erro_paridade, erro_formato;
   logic [3:0]  db_estado;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // pulse counters, written only by the monitor
   int n_pronto = 0, n_par = 0, n_fmt = 0, n_overlap = 0;
   logic [11:0] medida_no_pronto = '0;
   int p0, a0, f0;

   trena_receptor #(.CLK_POR_BIT(CPB), .TIMEOUT_CLKS(TO_CLKS)) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .medida         (medida),
      .pronto         (pronto),
      .erro_paridade  (erro_paridade),
      .erro_formato   (erro_formato),
      .db_estado      (db_estado)
   );

   // clock
   always #5 clock = ~clock;

   // monitor: count pulses on the falling edge
   always @(negedge clock) begin
      if (pronto) begin
         n_pronto = n_pronto + 1;
         medida_no_pronto = medida;
      end
      if (erro_paridade) n_par = n_par + 1;
      if (erro_formato)  n_fmt = n_fmt + 1;
      if (pronto && (erro_paridade || erro_formato)) n_overlap = n_overlap + 1;
      if (erro_paridade && erro_formato) n_overlap = n_overlap + 1;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_char(input logic [6:0] c, input logic flip_par, input logic bad_stop);
      logic par;
      par = ~(^c) ^ flip_par;
      entrada_serial = 1'b0;
      idle(CPB);
      for (int i = 0; i < 7; i++) begin
         entrada_serial = c[i];
         idle(CPB);
      end
      entrada_serial = par;
      idle(CPB);
      entrada_serial = ~bad_stop;
      idle(CPB);
      entrada_serial = 1'b1;
      if (bad_stop) idle(CPB);
   endtask

   task automatic send_msg(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
      send_char(a, 1'b0, 1'b0);
      send_char(b, 1'b0, 1'b0);
      send_char(c, 1'b0, 1'b0);
      send_char(d, 1'b0, 1'b0);
      idle(4);
   endtask

   task automatic snap();
      p0 = n_pronto; a0 = n_par; f0 = n_fmt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      cmp_cnt++; if (medida !== 12'h000) begin err_cnt++; $display("FAIL reset_medida got %h want 000", medida); end
      cmp_cnt++; if ({pronto, erro_paridade, erro_formato} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags got %b want 000", {pronto, erro_paridade, erro_formato}); end
      cmp_cnt++; if (db_estado !== 4'd0) begin err_cnt++; $display("FAIL reset_estado got %0d want 0", db_estado); end
      reset = 1'b0;
      idle(2 * CPB);
   endtask

   task automatic test_basic();
      snap();
      send_msg(7'h31, 7'h32, 7'h33, 7'h23);
      cmp_cnt++; if (n_pronto - p0 !== 1) begin err_cnt++; $display("FAIL basic_pronto got %0d want 1", n_pronto - p0); end
      cmp_cnt++; if (medida !== 12'h123) begin err_cnt++; $display("FAIL basic_medida got %h want 123", medida); end
      cmp_cnt++; if (medida_no_pronto !== 12'h123) begin err_cnt++; $display("FAIL basic_medida_at_pronto got %h want 123", medida_no_pronto); end
      cmp_cnt++; if ((n_par - a0) + (n_fmt - f0) !== 0) begin err_cnt++; $display("FAIL basic_errs got %0d want 0", (n_par - a0) + (n_fmt - f0)); end
   endtask

   task automatic test_parity();
      snap();
      send_char(7'h34, 1'b0, 1'b0);
      send_char(7'h35, 1'b1, 1'b0);
      idle(4);
      cmp_cnt++; if (n_par - a0 !== 1) begin err_cnt++; $display("FAIL par_on_5 got %0d want 1", n_par - a0); end
      cmp_cnt++; if (n_fmt - f0 !== 0) begin err_cnt++; $display("FAIL par_fmt_on_5 got %0d want 0", n_fmt - f0); end
      send_char(7'h36, 1'b0, 1'b0);
      send_char(7'h23, 1'b0, 1'b0);
      idle(4);
      cmp_cnt++; if (n_fmt - f0 !== 1) begin err_cnt++; $display("FAIL par_fmt_on_hash got %0d want 1", n_fmt - f0); end
      cmp_cnt++; if (n_pronto - p0 !== 0) begin err_cnt++; $display("FAIL par_pronto got %0d want 0", n_pronto - p0); end
      cmp_cnt++; if (medida !== 12'h123) begin err_cnt++; $display("FAIL par_medida got %h want 123", medida); end
   endtask

   task automatic test_early_hash();
      snap();
      send_char(7'h37, 1'b0, 1'b0);
      send_char(7'h38, 1'b0, 1'b0);
      send_char(7'h23, 1'b0, 1'b0);
      idle(4);
      cmp_cnt++; if (n_fmt - f0 !== 1) begin err_cnt++; $display("FAIL early_hash_fmt got %0d want 1", n_fmt - f0); end
      cmp_cnt++; if (medida !== 12'h123) begin err_cnt++; $display("FAIL early_hash_medida got %h want 123", medida); end
      snap();
      send_msg(7'h30, 7'h39, 7'h39, 7'h23);
      cmp_cnt++; if (medida !== 12'h099) begin err_cnt++; $display("FAIL msg099_medida got %h want 099", medida); end
      cmp_cnt++; if (n_pronto - p0 !== 1) begin err_cnt++; $display("FAIL msg099_pronto got %0d want 1", n_pronto - p0); end
   endtask

   task automatic test_digit_bounds();
      snap();
      send_char(7'h3A, 1'b0, 1'b0);
      send_char(7'h2F, 1'b0, 1'b0);
      idle(4);
      cmp_cnt++; if (n_fmt - f0 !== 2) begin err_cnt++; $display("FAIL bounds_fmt got %0d want 2", n_fmt - f0); end
      snap();
      send_msg(7'h39, 7'h30, 7'h30, 7'h23);
      cmp_cnt++; if (medida !== 12'h900) begin err_cnt++; $display("FAIL bounds_medida got %h want 900", medida); end
      cmp_cnt++; if (n_fmt - f0 !== 0) begin err_cnt++; $display("FAIL bounds_no_err got %0d want 0", n_fmt - f0); end
   endtask

   task automatic test_stop_priority();
      snap();
      send_char(7'h31, 1'b1, 1'b1);
      idle(4);
      cmp_cnt++; if (n_fmt - f0 !== 1) begin err_cnt++; $display("FAIL stopprio_fmt got %0d want 1", n_fmt - f0); end
      cmp_cnt++; if (n_par - a0 !== 0) begin err_cnt++; $display("FAIL stopprio_par got %0d want 0", n_par - a0); end
      cmp_cnt++; if (db_estado !== 4'd0) begin err_cnt++; $display("FAIL stopprio_estado got %0d want 0", db_estado); end
      send_msg(7'h33, 7'h32, 7'h31, 7'h23);
      cmp_cnt++; if (medida !== 12'h321) begin err_cnt++; $display("FAIL stopprio_medida got %h want 321", medida); end
   endtask

   task automatic test_glitch();
      snap();
      entrada_serial = 1'b0;
      idle(6);
      cmp_cnt++; if (db_estado !== 4'd1) begin err_cnt++; $display("FAIL glitch_verifica got %0d want 1", db_estado); end
      idle(4);
      entrada_serial = 1'b1;
      idle(20);
      cmp_cnt++; if (db_estado !== 4'd0) begin err_cnt++; $display("FAIL glitch_back got %0d want 0", db_estado); end
      cmp_cnt++; if ((n_par - a0) + (n_fmt - f0) + (n_pronto - p0) !== 0) begin err_cnt++; $display("FAIL glitch_flags got %0d want 0", (n_par - a0) + (n_fmt - f0) + (n_pronto - p0)); end
      send_msg(7'h35, 7'h35, 7'h35, 7'h23);
      cmp_cnt++; if (medida !== 12'h555) begin err_cnt++; $display("FAIL glitch_medida got %h want 555", medida); end
   endtask

   task automatic test_stuck_low_and_reset();
      snap();
      entrada_serial = 1'b0;
      idle(15 * CPB);
      cmp_cnt++; if (db_estado !== 4'd5) begin err_cnt++; $display("FAIL stuck_espera got %0d want 5", db_estado); end
      idle(5 * CPB);
      cmp_cnt++; if (db_estado !== 4'd5) begin err_cnt++; $display("FAIL stuck_still got %0d want 5", db_estado); end
      entrada_serial = 1'b1;
      idle(8);
      cmp_cnt++; if (db_estado !== 4'd0) begin err_cnt++; $display("FAIL stuck_release got %0d want 0", db_estado); end
      cmp_cnt++; if (n_fmt - f0 !== 1) begin err_cnt++; $display("FAIL stuck_fmt got %0d want 1", n_fmt - f0); end
      cmp_cnt++; if (n_par - a0 !== 0) begin err_cnt++; $display("FAIL stuck_par got %0d want 0", n_par - a0); end
      idle(CPB);
      // start a '7' frame and abort it in the middle of data bit 3
      entrada_serial = 1'b0;
      idle(CPB);
      entrada_serial = 1'b1; idle(CPB);
      entrada_serial = 1'b1; idle(CPB);
      entrada_serial = 1'b1; idle(CPB);
      entrada_serial = 1'b0; idle(CPB / 2);
      cmp_cnt++; if (db_estado !== 4'd2) begin err_cnt++; $display("FAIL midframe_recebe got %0d want 2", db_estado); end
      reset = 1'b1;
      entrada_serial = 1'b1;
      idle(2);
      cmp_cnt++; if (medida !== 12'h000) begin err_cnt++; $display("FAIL midreset_medida got %h want 000", medida); end
      cmp_cnt++; if ({pronto, erro_paridade, erro_formato} !== 3'b000) begin err_cnt++; $display("FAIL midreset_flags got %b want 000", {pronto, erro_paridade, erro_formato}); end
      cmp_cnt++; if (db_estado !== 4'd0) begin err_cnt++; $display("FAIL midreset_estado got %0d want 0", db_estado); end
      reset = 1'b0;
      idle(2 * CPB);
      snap();
      send_msg(7'h38, 7'h37, 7'h36, 7'h23);
      cmp_cnt++; if (medida !== 12'h876) begin err_cnt++; $display("FAIL postreset_medida got %h want 876", medida); end
      cmp_cnt++; if ((n_par - a0) + (n_fmt - f0) !== 0) begin err_cnt++; $display("FAIL postreset_errs got %0d want 0", (n_par - a0) + (n_fmt - f0)); end
   endtask

`ifdef TRENA_RX_TIMEOUT_EN
   task automatic test_timeout();
      snap();
      send_char(7'h31, 1'b0, 1'b0);
      idle(4900);
      cmp_cnt++; if (n_fmt - f0 !== 0) begin err_cnt++; $display("FAIL timeout_early got %0d want 0", n_fmt - f0); end
      idle(200);
      cmp_cnt++; if (n_fmt - f0 !== 1) begin err_cnt++; $display("FAIL timeout_fire got %0d want 1", n_fmt - f0); end
      snap();
      send_msg(7'h32, 7'h33, 7'h34, 7'h23);
      cmp_cnt++; if (medida !== 12'h234) begin err_cnt++; $display("FAIL timeout_medida got %h want 234", medida); end
      cmp_cnt++; if (n_pronto - p0 !== 1) begin err_cnt++; $display("FAIL timeout_pronto got %0d want 1", n_pronto - p0); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_early_hash();
      test_digit_bounds();
      test_stop_priority();
      test_glitch();
      test_stuck_low_and_reset();
`ifdef TRENA_RX_TIMEOUT_EN
      test_timeout();
`endif
      cmp_cnt++; if (n_overlap !== 0) begin err_cnt++; $display("FAIL flag_overlap got %0d want 0", n_overlap); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
